// File: rtl/fog_dac_tx_if.sv
// DAC-side serial bus of fog_dac_tx: SPI clock/data, frame select and LDAC strobe.
interface fog_dac_tx_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic ldac_n;

  modport master (
    output sclk,
    output mosi,
    output cs_n,
    output ldac_n
  );

  modport slave (
    input sclk,
    input mosi,
    input cs_n,
    input ldac_n
  );
endinterface

// File: rtl/fog_dac_tx.sv
// Serial DAC transmitter: snapshots phase-ramp / error words on load, converts them to
// offset-binary codes and shifts them as 24-bit SPI frames, then strobes LDAC.
module fog_dac_tx #(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_GAP    = 2,
  parameter int unsigned LDAC_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [31:0]         i_phaseRamp,
  input  logic [31:0]         i_err,
  input  logic [4:0]          i_err_shift,
  input  logic [1:0]          i_ch_en,
  fog_dac_tx_if.master        dac,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overrun
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] HalfLast = CntW'(SCLK_HALF - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(CS_GAP - 1);
  localparam logic [CntW-1:0] LdacLast = CntW'(LDAC_W - 1);

  typedef enum logic [2:0] {StIdle, StShift, StTail, StGap, StLdac, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic            phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
  logic            ch_q, ch_d;         // 0: channel A, 1: channel B
  logic [15:0]     ramp_q, ramp_d;
  logic [31:0]     err_q, err_d;
  logic [4:0]      shift_q, shift_d;
  logic [1:0]      en_q, en_d;

  logic sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

  logic signed [31:0] err_sh;
  logic [15:0]        code_b;
  logic [23:0]        frame;
  logic               cs_active;

  // Only the top half of the ramp word reaches the DAC.
  logic unused_ramp_lsb;
  assign unused_ramp_lsb = ^i_phaseRamp[15:0];

  // Next-state logic of the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    ch_d      = ch_q;
    ramp_d    = ramp_q;
    err_d     = err_q;
    shift_d   = shift_q;
    en_d      = en_q;
    overrun_d = i_load && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (i_load) begin
          ramp_d  = i_phaseRamp[31:16];
          err_d   = i_err;
          shift_d = i_err_shift;
          en_d    = i_ch_en;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = 5'd23;
          ch_d    = ~i_ch_en[0];
          state_d = (i_ch_en == 2'b00) ? StDone : StShift;
        end
      end
      StShift: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 5'd0) state_d = StTail;
            else               bit_d   = bit_q - 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTail: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (!ch_q && en_q[1]) begin
            ch_d    = 1'b1;
            bit_d   = 5'd23;
            phase_d = 1'b0;
            state_d = StShift;
          end else begin
            state_d = StLdac;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLdac: begin
        if (cnt_q == LdacLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, so every output is a flop aligned with its state.
  always_comb begin
    err_sh = $signed(err_d) >>> shift_d;
    if (err_sh > 32'sd32767)        code_b = 16'h7fff;
    else if (err_sh < -32'sd32768)  code_b = 16'h8000;
    else                            code_b = err_sh[15:0];

    if (ch_d) frame = {4'b0011, 4'd1, ~code_b[15], code_b[14:0]};
    else      frame = {4'b0011, 4'd0, ~ramp_d[15], ramp_d[14:0]};

    cs_active = (state_d == StShift) || (state_d == StTail);
    sclk_d    = (state_d == StShift) && phase_d;
    cs_n_d    = ~cs_active;
    mosi_d    = cs_active ? frame[bit_d] : 1'b0;
    ldac_n_d  = (state_d != StLdac);
    busy_d    = cs_active || (state_d == StGap) || (state_d == StLdac);
    done_d    = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      ch_q      <= 1'b0;
      ramp_q    <= '0;
      err_q     <= '0;
      shift_q   <= '0;
      en_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ldac_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      ch_q      <= ch_d;
      ramp_q    <= ramp_d;
      err_q     <= err_d;
      shift_q   <= shift_d;
      en_q      <= en_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ldac_n_q  <= ldac_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign dac.sclk   = sclk_q;
  assign dac.mosi   = mosi_q;
  assign dac.cs_n   = cs_n_q;
  assign dac.ldac_n = ldac_n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overrun  = overrun_q;

endmodule
